pcie3_intx_irq_ctrl: RTL and testbench

Legacy INTx interrupt controller on the user side of the PCIe3 `cfg_interrupt` interface. It aggregates level-sensitive interrupt requests from up to C_NUM_SRC user sources onto the four INTx pins (A–D). It sequences Assert_INTx/Deassert_INTx changes one pin at a time, honouring the core's `sent` handshake with a timeout. It drives the M-side `intx_vector`/`pending` signals that feed the `cfg_interrupt` wirethrough into the PCIe3 hard block.

---
 rtl/pcie3_intx_irq_ctrl_pkg.sv | 24 ++
 rtl/pcie3_intx_irq_ctrl_if.sv | 12 +
 rtl/pcie3_intx_irq_ctrl_rr_pick.sv | 27 ++
 rtl/pcie3_intx_irq_ctrl.sv | 95 +++++++++
 tb/tb_pcie3_intx_irq_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/pcie3_intx_irq_ctrl_pkg.sv
// Shared types and helpers for the PCIe3 legacy INTx interrupt controller.
// Holds the FSM state enum, the pin encodings and the source-to-pin decode.
package pcie3_intx_ctrl_pkg;

   localparam int unsigned INTX_PINS = 4;

   typedef enum logic [1:0] {
      PIN_A = 2'd0,
      PIN_B = 2'd1,
      PIN_C = 2'd2,
      PIN_D = 2'd3
   } intx_pin_e;

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_SENT = 1'b1
   } intx_state_e;

   // Callers zero-extend their 2*C_NUM_SRC-bit map to 64 bits (32 sources max).
   function automatic logic [1:0] src_pin(input logic [63:0] pin_map, input int unsigned src);
      return pin_map[2*src +: 2];
   endfunction

endpackage

// File: rtl/pcie3_intx_irq_ctrl_if.sv
// User-side cfg_interrupt INTx wirethrough to the PCIe3 hard block.
interface pcie3_intx_irq_ctrl_if;
   import pcie3_intx_ctrl_pkg::*;

   logic [INTX_PINS-1:0] m_intx_vector;
   logic                 m_sent;
   logic                 m_pending;

   modport master (output m_intx_vector, output m_pending, input m_sent);
   modport slave  (input m_intx_vector, input m_pending, output m_sent);

endinterface

// File: rtl/pcie3_intx_irq_ctrl_rr_pick.sv
// 4-way round-robin picker: grants the first requesting pin after the last grant.
module pcie3_intx_rr_pick
   import pcie3_intx_ctrl_pkg::*;
(
   input  logic [INTX_PINS-1:0] req,
   input  logic [1:0]           last,
   output logic [INTX_PINS-1:0] grant,
   output logic [1:0]           idx
);

   logic [1:0] cand;

   // k = INTX_PINS wraps back onto the last-granted pin, so it is checked last.
   always_comb begin
      grant = '0;
      idx   = last;
      cand  = last;
      for (int unsigned k = 1; k <= INTX_PINS; k++) begin
         cand = last + 2'(k);
         if (grant == '0 && req[cand]) begin
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/pcie3_intx_irq_ctrl.sv
// Legacy INTx aggregator: maps level sources onto pins A-D and sequences one
// Assert/Deassert_INTx change per cfg_interrupt sent handshake, with timeout.
module pcie3_intx_irq_ctrl
   import pcie3_intx_ctrl_pkg::*;
#(
   parameter int unsigned              C_NUM_SRC      = 8,
   parameter logic [2*C_NUM_SRC-1:0]   C_SRC_PIN_MAP  = '0,
   parameter int unsigned              C_SENT_TIMEOUT = 1024
)(
   input  logic                 user_clk,
   input  logic                 user_reset,
   input  logic [C_NUM_SRC-1:0] src_irq,
   input  logic [C_NUM_SRC-1:0] src_mask,
   input  logic                 intx_disable,
   pcie3_intx_irq_ctrl_if.master cfg,
   output logic                 busy,
   output logic                 timeout_err,
   input  logic                 err_clr
);

   localparam int unsigned CNT_W   = $clog2(C_SENT_TIMEOUT);
   localparam logic [63:0] PIN_MAP = 64'(C_SRC_PIN_MAP);
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(C_SENT_TIMEOUT - 1);

   intx_state_e          state;
   logic [C_NUM_SRC-1:0] irq_q;
   logic [INTX_PINS-1:0] want;
   logic [INTX_PINS-1:0] vec;
   logic [INTX_PINS-1:0] diff;
   logic [INTX_PINS-1:0] grant;
   logic [1:0]           grant_idx;
   logic [1:0]           last;
   logic [CNT_W-1:0]     cnt;
   logic                 pending;

   always_comb begin
      want = '0;
      for (int unsigned s = 0; s < C_NUM_SRC; s++) begin
         if (irq_q[s] && !src_mask[s]) want[src_pin(PIN_MAP, s)] = 1'b1;
      end
      if (intx_disable) want = '0;
   end

   assign diff = want ^ vec;

   pcie3_intx_rr_pick u_pick (
      .req   (diff),
      .last  (last),
      .grant (grant),
      .idx   (grant_idx)
   );

   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         state       <= IDLE;
         irq_q       <= '0;
         vec         <= '0;
         last        <= PIN_A;
         cnt         <= '0;
         pending     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         irq_q   <= src_irq;
         pending <= |want;
         // A timeout set later in this block overrides the clear.
         if (err_clr) timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (diff != '0) begin
                  vec   <= vec ^ grant;
                  last  <= grant_idx;
                  cnt   <= '0;
                  state <= WAIT_SENT;
               end
            end
            WAIT_SENT: begin
               if (cfg.m_sent) begin
                  state <= IDLE;
               end else if (cnt == CNT_TERM) begin
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cfg.m_intx_vector = vec;
   assign cfg.m_pending     = pending;
   assign busy              = (state == WAIT_SENT);

endmodule

// File: tb/tb_pcie3_intx_irq_ctrl.sv
// Scoreboard bench for pcie3_intx_irq_ctrl: a per-edge reference model queues
// expected outputs; a negedge monitor pops and compares them against the DUT.
module tb_pcie3_intx_irq_ctrl;

   localparam int unsigned NSRC = 8;
   localparam int unsigned TO   = 16;
   // Source s drives pin (3*s) mod 4: s0 A, s1 D, s2 C, s3 B, repeating.
   localparam logic [2*NSRC-1:0] MAP = 16'h6C6C;

   logic            clk = 1'b0;
   logic            rst;
   logic [NSRC-1:0] src_irq;
   logic [NSRC-1:0] src_mask;
   logic            dis;
   logic            busy;
   logic            err;
   logic            err_clr;

   pcie3_intx_irq_ctrl_if ifc ();

   pcie3_intx_irq_ctrl #(
      .C_NUM_SRC      (NSRC),
      .C_SRC_PIN_MAP  (MAP),
      .C_SENT_TIMEOUT (TO)
   ) dut (
      .user_clk     (clk),
      .user_reset   (rst),
      .src_irq      (src_irq),
      .src_mask     (src_mask),
      .intx_disable (dis),
      .cfg          (ifc),
      .busy         (busy),
      .timeout_err  (err),
      .err_clr      (err_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] vec;
      logic       pend;
      logic       busy;
      logic       err;
      logic       was_rst;
   } exp_t;

   exp_t q[$];
   int unsigned checks = 0;
   int unsigned errors = 0;

   // Reference model: tracks the delivered pin vector, the sampled requests and
   // how long the current message has been waiting, in plain integer terms.
   int unsigned m_irq, m_vec, m_last, m_wait;
   bit          m_busy, m_err, m_pend;

   always @(posedge clk) begin
      int unsigned want, d, p;
      bit set_err, found;
      exp_t e;
      if (rst) begin
         m_irq = 0; m_vec = 0; m_last = 0; m_wait = 0;
         m_busy = 0; m_err = 0; m_pend = 0;
      end else begin
         want = 0;
         for (int s = 0; s < NSRC; s++)
            if (m_irq[s] && !src_mask[s]) want = want | (1 << ((3 * s) % 4));
         if (dis) want = 0;
         set_err = 0;
         if (!m_busy) begin
            d = want ^ m_vec;
            found = 0;
            for (int k = 1; k <= 4; k++) begin
               p = (m_last + k) % 4;
               if (!found && d[p]) begin
                  found  = 1;
                  m_vec  = m_vec ^ (1 << p);
                  m_last = p;
                  m_busy = 1;
                  m_wait = 0;
               end
            end
         end else begin
            m_wait++;
            if (ifc.m_sent) m_busy = 0;
            else if (m_wait == TO) begin
               m_busy  = 0;
               set_err = 1;
            end
         end
         if (set_err) m_err = 1;
         else if (err_clr) m_err = 0;
         m_pend = (want != 0);
         m_irq  = src_irq;
      end
      e.vec = m_vec[3:0]; e.pend = m_pend; e.busy = m_busy; e.err = m_err;
      e.was_rst = rst;
      q.push_back(e);
   end

   logic [3:0] prev_vec = '0;

   always @(negedge clk) begin
      exp_t e;
      if (q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty at %0t: no expected record for DUT output", $time);
      end else begin
         e = q.pop_front();
         checks++;
         if (ifc.m_intx_vector !== e.vec || ifc.m_pending !== e.pend ||
             busy !== e.busy || err !== e.err) begin
            errors++;
            $display("FAIL outputs at %0t: actual vec=%b pend=%b busy=%b err=%b required vec=%b pend=%b busy=%b err=%b",
                     $time, ifc.m_intx_vector, ifc.m_pending, busy, err,
                     e.vec, e.pend, e.busy, e.err);
         end
         if (!e.was_rst && ifc.m_intx_vector !== prev_vec) begin
            checks++;
            if ($countones(ifc.m_intx_vector ^ prev_vec) != 1) begin
               errors++;
               $display("FAIL single_bit_change at %0t: actual %b -> %b required one bit changed",
                        $time, prev_vec, ifc.m_intx_vector);
            end
         end
      end
      prev_vec = ifc.m_intx_vector;
   end

   // Core-side responder: answers busy with m_sent after a random delay.
   bit resp_en  = 1'b1;
   bit noise_en = 1'b0;
   int resp_cnt = 0;

   always @(negedge clk) begin
      if (resp_en && busy && !ifc.m_sent) begin
         if (resp_cnt == 0) begin
            ifc.m_sent = 1'b1;
            resp_cnt = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 18) : $urandom_range(0, 4);
         end else begin
            resp_cnt--;
         end
      end else begin
         ifc.m_sent = !busy && noise_en && ($urandom_range(0, 7) == 0);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; src_irq = '0; src_mask = '0; dis = 1'b0; err_clr = 1'b0;
      cyc(3);
      rst = 1'b0;
      cyc(2);
      // Single source on pin A, then release.
      src_irq[0] = 1'b1; cyc(10);
      src_irq = '0;      cyc(10);
      // A and C together, then both dropped.
      src_irq = 8'b0000_0101; cyc(15);
      src_irq = '0;           cyc(15);
      // Short pulse on C while a pin D message is held waiting.
      resp_en = 1'b0;
      src_irq[1] = 1'b1; cyc(3);
      src_irq[2] = 1'b1; cyc(1);
      src_irq[2] = 1'b0; cyc(3);
      resp_en = 1'b1;    cyc(10);
      src_irq = '0;      cyc(10);
      // Timeouts: plain, clear, then clear held across a new timeout.
      resp_en = 1'b0;
      src_irq[3] = 1'b1; cyc(25);
      err_clr = 1'b1;    cyc(1);
      err_clr = 1'b0;    cyc(2);
      src_irq[3] = 1'b0;
      err_clr = 1'b1;    cyc(25);
      err_clr = 1'b0;
      resp_en = 1'b1;    cyc(5);
      err_clr = 1'b1;    cyc(1);
      err_clr = 1'b0;    cyc(3);
      // Interrupt Disable with A and B asserted.
      src_irq = 8'b1000_0001; cyc(15);
      dis = 1'b1;             cyc(15);
      dis = 1'b0;             cyc(15);
      // Reset while a message is in flight.
      resp_en = 1'b0;
      src_irq = '0; cyc(4);
      rst = 1'b1;   cyc(1);
      rst = 1'b0;
      resp_en = 1'b1; cyc(10);
      // Randomised traffic.
      noise_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) src_irq = src_irq ^ NSRC'(1 << $urandom_range(0, NSRC - 1));
         if ($urandom_range(0, 40) == 0) src_mask = NSRC'($urandom);
         if ($urandom_range(0, 150) == 0) dis = ~dis;
         err_clr = ($urandom_range(0, 15) == 0);
         rst = ($urandom_range(0, 700) == 0);
         cyc(1);
      end
      rst = 1'b0; err_clr = 1'b0; dis = 1'b0; noise_en = 1'b0;
      cyc(40);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
